stack_exec_ctrl: RTL and testbench

- Execution controller that sits directly upstream of the hardware LIFO in the stack-ISA datapath.
- Accepts stack-machine instructions over a valid/ready handshake and sequences the LIFO push/pop port to execute them.
- Supports PUSHI, POP, DUP and the binary ALU ops ADD/SUB/AND/OR; reports a result, done pulse and error pulse per instruction.
- Keeps an internal occupancy counter so stack underflow/overflow is rejected before any stack activity.

---
 rtl/stack_exec_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stack_exec_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_exec_ctrl.sv
// Execution controller for the stack ISA: accepts one instruction at a time and
// sequences push/pop strobes on the attached LIFO, tracking occupancy locally.
module stack_exec_ctrl #(
  parameter int DATA_WIDTH  = 6,
  parameter int STACK_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          asyn_rst,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [2:0]                    instr_op,
  input  logic [DATA_WIDTH-1:0]         instr_imm,
  output logic                          done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         result,
  output logic [$clog2(STACK_DEPTH):0]  depth,
  output logic                          stk_push,
  output logic                          stk_pop,
  output logic [DATA_WIDTH-1:0]         stk_din,
  input  logic [DATA_WIDTH-1:0]         stk_dout,
  input  logic                          stk_full,
  input  logic                          stk_empty
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [DEPTH_W-1:0] FULL_LEVEL = DEPTH_W'(STACK_DEPTH);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSHI = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_DUP   = 3'b111;

  typedef enum logic [2:0] {
    IDLE, CHK, POP1, POP2, PUSHR, DUP2, POPW, FIN
  } state_t;

  state_t                  state, next_state;
  logic [2:0]              op_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   alu;
  logic                    legal;

  // The LIFO flags are redundant with the local occupancy count.
  logic unused_flags;
  assign unused_flags = ^{stk_full, stk_empty};

  // Legality is judged from the occupancy at the accept edge, so a rejected
  // instruction never touches the stack.
  always_comb begin
    legal = 1'b0;
    case (instr_op)
      OP_NOP:                       legal = 1'b1;
      OP_PUSHI:                     legal = (depth < FULL_LEVEL);
      OP_POP:                       legal = (depth >= DEPTH_W'(1));
      OP_DUP:                       legal = (depth >= DEPTH_W'(1)) && (depth < FULL_LEVEL);
      OP_ADD, OP_SUB, OP_AND, OP_OR: legal = (depth >= DEPTH_W'(2));
      default:                      legal = 1'b0;
    endcase
  end

  // b is on stk_dout during PUSHR; a is the old top captured in POP2.
  always_comb begin
    alu = '0;
    case (op_q)
      OP_ADD:  alu = stk_dout + a_q;
      OP_SUB:  alu = stk_dout - a_q;
      OP_AND:  alu = stk_dout & a_q;
      OP_OR:   alu = stk_dout | a_q;
      default: alu = '0;
    endcase
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_din     = '0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (!legal)
            next_state = CHK;
          else if (instr_op == OP_NOP || instr_op == OP_PUSHI)
            next_state = FIN;
          else
            next_state = POP1;
        end
      end
      CHK: next_state = IDLE;
      FIN: begin
        if (op_q == OP_PUSHI) begin
          stk_push = 1'b1;
          stk_din  = imm_q;
        end
        next_state = IDLE;
      end
      POP1: begin
        stk_pop = 1'b1;
        if (op_q == OP_POP)
          next_state = POPW;
        else if (op_q == OP_DUP)
          next_state = DUP2;
        else
          next_state = POP2;
      end
      POP2: begin
        stk_pop    = 1'b1;
        next_state = PUSHR;
      end
      DUP2: begin
        stk_push   = 1'b1;
        stk_din    = stk_dout;
        next_state = PUSHR;
      end
      PUSHR: begin
        stk_push   = 1'b1;
        stk_din    = (op_q == OP_DUP) ? a_q : alu;
        next_state = IDLE;
      end
      POPW: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // done/err are registered so they appear in the first IDLE cycle after the
  // instruction, which is also the cycle a following instruction may be taken.
  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state  <= IDLE;
      op_q   <= OP_NOP;
      imm_q  <= '0;
      a_q    <= '0;
      result <= '0;
      depth  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state != IDLE) && (next_state == IDLE);
      err   <= (state == CHK);
      if (state == IDLE && instr_valid) begin
        op_q  <= instr_op;
        imm_q <= instr_imm;
      end
      if (state == POP2 || state == DUP2)
        a_q <= stk_dout;
      if (state == POPW)
        result <= stk_dout;
      else if (state == PUSHR)
        result <= stk_din;
      if (stk_push)
        depth <= depth + DEPTH_W'(1);
      else if (stk_pop)
        depth <= depth - DEPTH_W'(1);
    end
  end

endmodule

// File: tb/tb_stack_exec_ctrl.sv
// Bench for stack_exec_ctrl: a behavioural LIFO drives stk_dout, and an
// instruction-level queue model predicts result, err, depth, latency and strobes.
module tb_stack_exec_ctrl;

  localparam int DW   = 6;
  localparam int SD   = 16;
  localparam int MASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          asyn_rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [DW-1:0] instr_imm;
  logic          done, err;
  logic [DW-1:0] result;
  logic [4:0]    depth;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic          stk_full, stk_empty;

  int checks   = 0;
  int failures = 0;

  int model_stk[$];
  int model_result = 0;

  always #5 clk = ~clk;

  stack_exec_ctrl #(.DATA_WIDTH(DW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .asyn_rst(asyn_rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm),
    .done(done), .err(err), .result(result), .depth(depth),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  // Attached LIFO: read data appears the edge after a pop strobe.
  logic [DW-1:0] lifo_mem [SD];
  int            lifo_cnt;

  always @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      lifo_cnt <= 0;
      stk_dout <= '0;
    end else if (stk_pop && lifo_cnt > 0) begin
      stk_dout <= lifo_mem[lifo_cnt-1];
      lifo_cnt <= lifo_cnt - 1;
    end else if (stk_push && lifo_cnt < SD) begin
      lifo_mem[lifo_cnt] <= stk_din;
      lifo_cnt <= lifo_cnt + 1;
    end
  end

  assign stk_full  = (lifo_cnt == SD);
  assign stk_empty = (lifo_cnt == 0);

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op    = 3'd0;
    instr_imm   = '0;
    asyn_rst    = 1'b1;
    @(negedge clk);
    asyn_rst = 1'b0;
    model_stk.delete();
    model_result = 0;
  endtask

  // Issue one instruction, predict its effect from the ISA rules, and check.
  task automatic issue(input int op, input int imm);
    int d, a, b, t, r, lat, exp_lat, exp_err, exp_pops, pops_seen, w;
    int exp_push[$];
    int push_seen[$];
    bit both;
    d = model_stk.size();
    exp_err = 0; exp_pops = 0; exp_lat = 2; lat = 0; pops_seen = 0; both = 0;
    if ((op == 1 && d >= SD) || (op == 2 && d < 1) || (op == 7 && (d < 1 || d >= SD)) ||
        (op >= 3 && op <= 6 && d < 2)) begin
      exp_err = 1;
    end else begin
      case (op)
        1: begin
          exp_push.push_back(imm & MASK);
          model_stk.push_back(imm & MASK);
        end
        2: begin
          exp_lat = 3; exp_pops = 1;
          model_result = model_stk.pop_back();
        end
        3, 4, 5, 6: begin
          exp_lat = 4; exp_pops = 2;
          a = model_stk.pop_back();
          b = model_stk.pop_back();
          case (op)
            3: r = (b + a) & MASK;
            4: r = (b - a) & MASK;
            5: r = b & a;
            default: r = b | a;
          endcase
          exp_push.push_back(r);
          model_stk.push_back(r);
          model_result = r;
        end
        7: begin
          exp_lat = 4; exp_pops = 1;
          t = model_stk[model_stk.size()-1];
          exp_push.push_back(t);
          exp_push.push_back(t);
          model_stk.push_back(t);
          model_result = t;
        end
        default: ;
      endcase
    end

    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!instr_ready) begin
      failures++;
      $display("[TB] FAIL ready_wait op=%0d: instr_ready=%0b required 1", op, instr_ready);
      return;
    end
    instr_valid = 1'b1;
    instr_op    = 3'(op);
    instr_imm   = DW'(imm);
    @(posedge clk);
    #1;
    if ($urandom_range(1, 0) == 1) begin
      instr_op  = 3'($urandom);
      instr_imm = DW'($urandom);
    end else begin
      instr_valid = 1'b0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (stk_push && stk_pop) both = 1;
      if (stk_push) push_seen.push_back(int'(stk_din));
      if (stk_pop) pops_seen++;
      if (done) begin
        lat = k;
        break;
      end
    end
    instr_valid = 1'b0;

    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("[TB] FAIL latency op=%0d: done after %0d cycles, required %0d", op, lat, exp_lat);
    end
    checks++;
    if (err !== 1'(exp_err)) begin
      failures++;
      $display("[TB] FAIL err op=%0d: err=%0b required %0d", op, err, exp_err);
    end
    checks++;
    if (result !== DW'(model_result)) begin
      failures++;
      $display("[TB] FAIL result op=%0d: result=%0d required %0d", op, result, model_result);
    end
    checks++;
    if (depth !== 5'(model_stk.size())) begin
      failures++;
      $display("[TB] FAIL depth op=%0d: depth=%0d required %0d", op, depth, model_stk.size());
    end
    checks++;
    if (pops_seen != exp_pops) begin
      failures++;
      $display("[TB] FAIL pop_count op=%0d: pops=%0d required %0d", op, pops_seen, exp_pops);
    end
    checks++;
    if (push_seen.size() != exp_push.size()) begin
      failures++;
      $display("[TB] FAIL push_count op=%0d: pushes=%0d required %0d", op, push_seen.size(), exp_push.size());
    end else begin
      for (int i = 0; i < exp_push.size(); i++) begin
        checks++;
        if (push_seen[i] != exp_push[i]) begin
          failures++;
          $display("[TB] FAIL push_data op=%0d idx=%0d: din=%0d required %0d", op, i, push_seen[i], exp_push[i]);
        end
      end
    end
    checks++;
    if (both) begin
      failures++;
      $display("[TB] FAIL strobe_overlap op=%0d: push and pop both high, required exclusive", op);
    end
    checks++;
    if (stk_empty !== (depth == 0) || stk_full !== (depth == 5'(SD))) begin
      failures++;
      $display("[TB] FAIL flags op=%0d: empty=%0b full=%0b depth=%0d, required consistent", op, stk_empty, stk_full, depth);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (instr_ready !== 1'b1 || depth !== 5'd0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: ready=%0b depth=%0d done=%0b err=%0b required 1/0/0/0", instr_ready, depth, done, err);
    end
    checks++;
    if (result !== '0 || stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_din !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: result=%0d push=%0b pop=%0b din=%0d required all 0", result, stk_push, stk_pop, stk_din);
    end
  endtask

  task automatic test_sub_pop();
    reset_dut();
    issue(1, 5);
    issue(1, 3);
    issue(4, 0);
    checks++;
    if (result !== 6'd2) begin
      failures++;
      $display("[TB] FAIL sub_result: result=%0d required 2", result);
    end
    issue(2, 0);
    checks++;
    if (result !== 6'd2 || depth !== 5'd0) begin
      failures++;
      $display("[TB] FAIL pop_after_sub: result=%0d depth=%0d required 2/0", result, depth);
    end
  endtask

  task automatic test_alu();
    reset_dut();
    issue(1, 60);
    issue(1, 10);
    issue(3, 0);
    checks++;
    if (result !== 6'd6 || depth !== 5'd1) begin
      failures++;
      $display("[TB] FAIL add_wrap: result=%0d depth=%0d required 6/1", result, depth);
    end
    issue(2, 0);
    issue(1, 'h2A);
    issue(1, 'h0F);
    issue(5, 0);
    checks++;
    if (result !== 6'h0A) begin
      failures++;
      $display("[TB] FAIL and_result: result=%0h required 0a", result);
    end
    issue(1, 'h30);
    issue(1, 'h05);
    issue(6, 0);
    checks++;
    if (result !== 6'h35) begin
      failures++;
      $display("[TB] FAIL or_result: result=%0h required 35", result);
    end
  endtask

  task automatic test_underflow();
    reset_dut();
    issue(1, 11);
    issue(4, 0);
    issue(3, 0);
    issue(2, 0);
    issue(2, 0);
    issue(7, 0);
    issue(0, 0);
    checks++;
    if (result !== 6'd11 || depth !== 5'd0) begin
      failures++;
      $display("[TB] FAIL underflow_state: result=%0d depth=%0d required 11/0", result, depth);
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 1; i <= SD; i++) issue(1, i);
    checks++;
    if (depth !== 5'd16 || stk_full !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full: depth=%0d full=%0b required 16/1", depth, stk_full);
    end
    issue(1, 33);
    issue(7, 0);
    issue(2, 0);
    checks++;
    if (result !== 6'd16) begin
      failures++;
      $display("[TB] FAIL pop_top_of_full: result=%0d required 16", result);
    end
  endtask

  task automatic test_dup();
    reset_dut();
    issue(1, 9);
    issue(7, 0);
    checks++;
    if (result !== 6'd9 || depth !== 5'd2) begin
      failures++;
      $display("[TB] FAIL dup: result=%0d depth=%0d required 9/2", result, depth);
    end
    issue(3, 0);
    checks++;
    if (result !== 6'd18) begin
      failures++;
      $display("[TB] FAIL dup_add: result=%0d required 18", result);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    reset_dut();
    issue(1, 20);
    issue(1, 22);
    instr_valid = 1'b1;
    instr_op    = 3'd3;
    instr_imm   = '0;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    asyn_rst = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || depth !== 5'd0 || stk_push !== 1'b0 || stk_pop !== 1'b0 ||
        result !== '0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: ready=%0b depth=%0d push=%0b pop=%0b result=%0d done=%0b required 1/0/0/0/0/0",
               instr_ready, depth, stk_push, stk_pop, result, done);
    end
    @(negedge clk);
    asyn_rst = 1'b0;
    model_stk.delete();
    model_result = 0;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("[TB] FAIL abandoned_done: done pulses=%0d required 0", seen_done);
    end
    issue(1, 7);
    issue(2, 0);
    checks++;
    if (result !== 6'd7) begin
      failures++;
      $display("[TB] FAIL after_reset_pop: result=%0d required 7", result);
    end
  endtask

  task automatic test_random();
    int op;
    reset_dut();
    for (int n = 0; n < 250; n++) begin
      if (model_stk.size() < 3 && $urandom_range(1, 0) == 1)
        op = 1;
      else
        op = $urandom_range(7, 0);
      issue(op, $urandom_range(MASK, 0));
    end
  endtask

  initial begin
    asyn_rst    = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 3'd0;
    instr_imm   = '0;
    test_reset();
    test_sub_pop();
    test_alu();
    test_underflow();
    test_back_to_back();
    test_dup();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
